// File: rtl/scrambler_keystream_gen.sv
// Keystream generator for the video scrambler: a 256-bit Fibonacci LFSR seeded from
// configuration, reloaded on every frame start, advancing KEY_W bits per accepted key.
module scrambler_keystream_gen #(
  parameter int            KEY_W         = 8,
  parameter int            WARMUP_CYCLES = 4,
  parameter logic [255:0]  ZERO_SUB      = 256'h1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reset_n_scrambler,
  input  logic             mode,
  input  logic [255:0]     seed,
  input  logic             frame_start,
  input  logic             key_ready,
  output logic             key_valid,
  output logic [KEY_W-1:0] key,
  output logic             key_mode,
  output logic [15:0]      keys_in_frame,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WARMUP, S_RUN} state_t;

  localparam logic [7:0] W_LAST = 8'(WARMUP_CYCLES - 1);

  state_t       r_state, w_next;
  logic [255:0] r_lfsr, w_adv;
  logic [7:0]   r_wcnt;
  logic         r_cfg_q;
  logic         r_key_mode;
  logic [15:0]  r_kif;

  // KEY_W unrolled steps of x^256+x^254+x^251+x^246+1
  function automatic logic [255:0] f_advance(input logic [255:0] s);
    logic [255:0] t;
    t = s;
    for (int i = 0; i < KEY_W; i++)
      t = {t[254:0], t[255] ^ t[253] ^ t[250] ^ t[245]};
    return t;
  endfunction

  assign w_adv = f_advance(r_lfsr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Leaving IDLE waits for config-valid to be seen on two consecutive edges;
  // a drop of config-valid is acted on immediately and beats frame_start.
  always_comb begin
    w_next = r_state;
    if (!reset_n_scrambler) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (r_cfg_q) w_next = S_LOAD;
        S_LOAD:   if (frame_start)             w_next = S_LOAD;
                  else if (WARMUP_CYCLES > 0)  w_next = S_WARMUP;
                  else                         w_next = S_RUN;
        S_WARMUP: if (frame_start)             w_next = S_LOAD;
                  else if (r_wcnt == W_LAST)   w_next = S_RUN;
        S_RUN:    if (frame_start)             w_next = S_LOAD;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr     <= '0;
      r_key_mode <= 1'b0;
      r_kif      <= '0;
      r_wcnt     <= '0;
      r_cfg_q    <= 1'b0;
    end else begin
      r_cfg_q <= reset_n_scrambler;
      case (r_state)
        S_LOAD: begin
          r_lfsr     <= (seed == '0) ? ZERO_SUB : seed;
          r_key_mode <= mode;
          r_kif      <= '0;
          r_wcnt     <= '0;
        end
        S_WARMUP: begin
          r_lfsr <= w_adv;
          r_wcnt <= r_wcnt + 8'd1;
        end
        S_RUN: begin
          // a handshake coinciding with frame_start still counts; LOAD overwrites lfsr next
          if (key_ready) begin
            r_lfsr <= w_adv;
            if (r_kif != 16'hFFFF) r_kif <= r_kif + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign key_valid     = (r_state == S_RUN);
  assign busy          = (r_state == S_LOAD) || (r_state == S_WARMUP);
  assign key           = r_lfsr[255 -: KEY_W];
  assign key_mode      = r_key_mode;
  assign keys_in_frame = r_kif;

endmodule

// File: tb/tb_scrambler_keystream_gen.sv
// Bench for scrambler_keystream_gen: two instances (no warmup / 4-cycle warmup) driven in
// lockstep, keys checked against a bit-sequence recurrence of the LFSR polynomial.
module tb_scrambler_keystream_gen;
  localparam int K  = 8;
  localparam int W1 = 4;

  logic         clk = 1'b0;
  logic         reset_n, rsn, mode, fs, ready;
  logic [255:0] seed;
  logic         kv0, kv1, km0, km1, busy0, busy1;
  logic [K-1:0] key0, key1;
  logic [15:0]  kif0, kif1;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  logic [255:0] cur_seed;
  logic [255:0] sd_a;

  always #5 clk = ~clk;

  scrambler_keystream_gen #(.KEY_W(K), .WARMUP_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .reset_n_scrambler(rsn), .mode(mode), .seed(seed),
    .frame_start(fs), .key_ready(ready), .key_valid(kv0), .key(key0), .key_mode(km0),
    .keys_in_frame(kif0), .busy(busy0));

  scrambler_keystream_gen #(.KEY_W(K), .WARMUP_CYCLES(W1)) dut1 (
    .clk(clk), .reset_n(reset_n), .reset_n_scrambler(rsn), .mode(mode), .seed(seed),
    .frame_start(fs), .key_ready(ready), .key_valid(kv1), .key(key1), .key_mode(km1),
    .keys_in_frame(kif1), .busy(busy1));

  // Output bit stream: b[0..255] = effective seed MSB first, b[n+256] = b[n]^b[n+2]^b[n+5]^b[n+10].
  // The key after advancing pos bits is b[pos .. pos+K-1], first bit as MSB.
  function automatic logic [K-1:0] mkey(input logic [255:0] sd, input int pos);
    logic [255:0] s;
    logic [K-1:0] r;
    bit b[];
    int n;
    s = (sd == '0) ? 256'h1 : sd;
    n = (pos + K > 256) ? pos + K : 256;
    b = new[n];
    for (int i = 0; i < 256; i++) b[i] = s[255-i];
    for (int i = 256; i < n; i++) b[i] = b[i-256] ^ b[i-254] ^ b[i-251] ^ b[i-246];
    for (int j = 0; j < K; j++) r[K-1-j] = b[pos+j];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_run(input string tag);
    chk({tag, "_v"},  32'({kv0, kv1}), 32'b11);
    chk({tag, "_k0"}, 32'(key0), 32'(mkey(cur_seed, k * K)));
    chk({tag, "_k1"}, 32'(key1), 32'(mkey(cur_seed, (W1 + k) * K)));
    chk({tag, "_n0"}, 32'(kif0), 32'(k));
    chk({tag, "_n1"}, 32'(kif1), 32'(k));
  endtask

  // Samples the reload from the current cycle on; returns first-valid index and busy counts.
  task automatic measure(output int lat0, output int lat1, output int b0, output int b1);
    lat0 = -1; lat1 = -1; b0 = 0; b1 = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (kv0 && lat0 < 0) lat0 = c;
      if (kv1 && lat1 < 0) lat1 = c;
      b0 += int'(busy0);
      b1 += int'(busy1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, l1, bc0, bc1;
    sd_a = {8'hA5, 248'h0};
    reset_n = 1'b0; rsn = 1'b0; mode = 1'b0; seed = '0; fs = 1'b0; ready = 1'b0;
    #12;
    chk("rst0", 32'({kv0, key0, km0, kif0, busy0}), 32'd0);
    chk("rst1", 32'({kv1, key1, km1, kif1, busy1}), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    // T1: first load, latency, first key and one handshake
    seed = sd_a; mode = 1'b1; rsn = 1'b1; cur_seed = sd_a; k = 0;
    measure(l0, l1, bc0, bc1);
    chk("t1_lat0", 32'(l0), 32'd2);
    chk("t1_lat1", 32'(l1), 32'(2 + W1));
    chk("t1_busy0", 32'(bc0), 32'd1);
    chk("t1_busy1", 32'(bc1), 32'(1 + W1));
    chk("t1_a5", 32'(key0), 32'h A5);
    chk("t1_mode", 32'({km0, km1}), 32'b11);
    chk_run("t1_first");
    ready = 1'b1; tick(); ready = 1'b0; k++;
    chk("t1_00", 32'(key0), 32'h00);
    chk_run("t1_hs");

    // T2: all-zero seed replaced by the lock-up guard value
    seed = '0; mode = 1'b0; fs = 1'b1; tick(); fs = 1'b0;
    chk("t2_drop", 32'({kv0, kv1, busy0, busy1}), 32'b0011);
    bc0 = int'(busy0); bc1 = int'(busy1);
    for (int c = 0; c < 8; c++) begin
      tick(); bc0 += int'(busy0); bc1 += int'(busy1);
    end
    chk("t2_busy0", 32'(bc0), 32'd1);
    chk("t2_busy1", 32'(bc1), 32'(1 + W1));
    cur_seed = '0; k = 0;
    chk("t2_first", 32'(key0), 32'h00);
    chk("t2_mode", 32'({km0, km1}), 32'b00);
    chk_run("t2_load");
    ready = 1'b1; repeat (31) tick(); ready = 1'b0; k += 31;
    chk("t2_01", 32'(key0), 32'h01);
    chk_run("t2_31");

    // T3: stall holds key and count, then back-to-back keys
    for (int c = 0; c < 10; c++) begin tick(); chk_run("t3_hold"); end
    ready = 1'b1;
    for (int c = 0; c < 5; c++) begin tick(); k++; chk_run("t3_burst"); end
    ready = 1'b0;
    chk("t3_cnt", 32'(kif1), 32'd36);

    // Random seed and random ready; seed input wiggles outside LOAD without effect
    cur_seed = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    seed = cur_seed; mode = 1'($urandom_range(0, 1)); fs = 1'b1; tick(); fs = 1'b0;
    repeat (6) tick();
    k = 0;
    chk("rnd_mode", 32'({km0, km1}), 32'({mode, mode}));
    chk_run("rnd_load");
    for (int c = 0; c < 40; c++) begin
      ready = 1'($urandom_range(0, 1));
      seed  = {8{$urandom}};
      tick();
      if (ready) k++;
      chk_run("rnd");
    end
    ready = 1'b0;

    // T4: frame_start with a handshake after 7 keys
    seed = sd_a; cur_seed = sd_a; mode = 1'b1; fs = 1'b1; tick(); fs = 1'b0;
    repeat (6) tick();
    k = 0;
    ready = 1'b1; repeat (7) tick(); k = 7;
    chk_run("t4_seven");
    fs = 1'b1; tick(); fs = 1'b0; ready = 1'b0;
    chk("t4_cnt0", 32'(kif0), 32'd8);
    chk("t4_cnt1", 32'(kif1), 32'd8);
    chk("t4_drop", 32'({kv0, kv1, busy0, busy1}), 32'b0011);
    bc0 = int'(busy0); bc1 = int'(busy1);
    for (int c = 0; c < 8; c++) begin
      tick(); bc0 += int'(busy0); bc1 += int'(busy1);
    end
    chk("t4_busy0", 32'(bc0), 32'd1);
    chk("t4_busy1", 32'(bc1), 32'(1 + W1));
    k = 0;
    chk("t4_a5", 32'(key0), 32'hA5);
    chk_run("t4_reload");

    // T5: config-valid dropped mid-warmup, then reasserted
    fs = 1'b1; tick(); fs = 1'b0;
    tick(); tick();
    chk("t5_warm", 32'(busy1), 32'd1);
    rsn = 1'b0; tick();
    chk("t5_idle", 32'({kv0, kv1, busy0, busy1}), 32'b0000);
    chk("t5_mode", 32'({km0, km1}), 32'b11);
    tick(); tick();
    chk("t5_stay", 32'({kv0, kv1, busy0, busy1}), 32'b0000);
    rsn = 1'b1;
    measure(l0, l1, bc0, bc1);
    chk("t5_lat0", 32'(l0), 32'd2);
    chk("t5_lat1", 32'(l1), 32'(2 + W1));
    k = 0;
    chk_run("t5_reload");
    ready = 1'b1;
    for (int c = 0; c < 3; c++) begin tick(); k++; chk_run("t5_seq"); end
    ready = 1'b0;

    // T6: async reset mid-run, then count saturation
    ready = 1'b1; tick(); tick();
    #3 reset_n = 1'b0;
    #1;
    chk("t6_rst0", 32'({kv0, key0, km0, kif0, busy0}), 32'd0);
    chk("t6_rst1", 32'({kv1, key1, km1, kif1, busy1}), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (65560) tick();
    chk("t6_sat0", 32'(kif0), 32'hFFFF);
    chk("t6_sat1", 32'(kif1), 32'hFFFF);
    chk("t6_run", 32'({kv0, kv1}), 32'b11);
    ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
